// File: rtl/bayer_window_engine.sv
// Streams a raster Bayer frame through a one-line cache and emits every 2x2
// window, reordered so R/G1/G2/B land in fixed lanes regardless of phase.
module bayer_window_engine #(
  parameter int unsigned PIX_W    = 8,
  parameter int unsigned DIM_W    = 13,
  parameter int unsigned MAX_COLS = 4096
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [DIM_W-1:0]   img_width_i,
  input  logic [DIM_W-1:0]   img_height_i,
  input  logic               in_valid_i,
  input  logic [PIX_W-1:0]   in_pix_i,
  output logic               in_ready_o,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [4*PIX_W-1:0] out_win_o,
  output logic [DIM_W-1:0]   out_row_o,
  output logic [DIM_W-1:0]   out_col_o,
  output logic               out_last_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_cfg_o
);

  localparam int unsigned AW    = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
  localparam int unsigned WIN_W = 4 * PIX_W;
  localparam int unsigned DW1   = DIM_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_FLUSH} state_e;

  state_e             state_q, state_d;
  logic               start_q;
  logic [DIM_W-1:0]   width_q, height_q;
  logic [DIM_W-1:0]   i_q, j_q;
  logic [PIX_W-1:0]   prev_top_q, prev_bot_q;
  logic [PIX_W-1:0]   cache_q [MAX_COLS];
  logic               out_valid_q, out_last_q, err_cfg_q;
  logic [WIN_W-1:0]   out_win_q;
  logic [DIM_W-1:0]   out_row_q, out_col_q;

  logic               start_edge, cfg_ok, launch, accept, col_end, row_end;
  logic               win_load, out_fire;
  logic [AW-1:0]      cache_addr;
  logic [PIX_W-1:0]   top_pix;
  logic [WIN_W-1:0]   win_ordered;

  assign start_edge = start_i && !start_q;
  assign cfg_ok     = (img_width_i >= DIM_W'(2))
                   && ({1'b0, img_width_i} <= DW1'(MAX_COLS))
                   && (img_height_i >= DIM_W'(2));
  assign launch     = (state_q == S_IDLE) && start_edge && cfg_ok;
  assign accept     = in_valid_i && in_ready_o;
  assign col_end    = (i_q == width_q - DIM_W'(1));
  assign row_end    = (j_q == height_q - DIM_W'(1));
  assign out_fire   = out_valid_q && out_ready_i;
  assign win_load   = accept && (state_q == S_RUN) && (i_q != '0);
  assign cache_addr = AW'(i_q);
  assign top_pix    = cache_q[cache_addr];

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (launch) state_d = S_FILL;
      S_FILL:  if (accept && col_end) state_d = S_RUN;
      S_RUN:   if (accept && col_end && row_end) state_d = S_FLUSH;
      S_FLUSH: if (out_fire && out_last_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    in_ready_o = 1'b0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    unique case (state_q)
      S_FILL, S_RUN: begin
        in_ready_o = !out_valid_q || out_ready_i;
        busy_o     = 1'b1;
      end
      S_FLUSH: begin
        busy_o = 1'b1;
        done_o = out_fire && out_last_q;
      end
      default: ;
    endcase
  end

  // Start edge detector; resets high so a held start never launches
  always_ff @(posedge clk_i) begin
    if (rst_i) start_q <= 1'b1;
    else       start_q <= start_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      width_q   <= '0;
      height_q  <= '0;
      err_cfg_q <= 1'b0;
    end else begin
      err_cfg_q <= (state_q == S_IDLE) && start_edge && !cfg_ok;
      if (launch) begin
        width_q  <= img_width_i;
        height_q <= img_height_i;
      end
    end
  end

  // Raster position of the pixel currently offered
  always_ff @(posedge clk_i) begin
    if (rst_i || launch) begin
      i_q <= '0;
      j_q <= '0;
    end else if (accept) begin
      if (col_end) begin
        i_q <= '0;
        j_q <= row_end ? '0 : j_q + DIM_W'(1);
      end else begin
        i_q <= i_q + DIM_W'(1);
      end
    end
  end

  // Line cache and left-column pair; contents are meaningless after reset
  always_ff @(posedge clk_i) begin
    if (accept) cache_q[cache_addr] <= in_pix_i;
    if (accept && (state_q == S_RUN)) begin
      prev_top_q <= top_pix;
      prev_bot_q <= in_pix_i;
    end
  end

  // Phase of the top-left pixel is the parity of (j-1, i-1)
  always_comb begin
    win_ordered = '0;
    unique case ({~j_q[0], ~i_q[0]})
      2'b00:   win_ordered = {prev_top_q, top_pix, prev_bot_q, in_pix_i};
      2'b01:   win_ordered = {top_pix, prev_top_q, in_pix_i, prev_bot_q};
      2'b10:   win_ordered = {prev_bot_q, in_pix_i, prev_top_q, top_pix};
      default: win_ordered = {in_pix_i, prev_bot_q, top_pix, prev_top_q};
    endcase
  end

  // Single output register; holds while stalled
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_win_q   <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
    end else if (win_load) begin
      out_valid_q <= 1'b1;
      out_last_q  <= col_end && row_end;
      out_win_q   <= win_ordered;
      out_row_q   <= j_q;
      out_col_q   <= i_q;
    end else if (out_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_last_o  = out_last_q;
  assign out_win_o   = out_win_q;
  assign out_row_o   = out_row_q;
  assign out_col_o   = out_col_q;
  assign err_cfg_o   = err_cfg_q;

endmodule

// File: doc/bayer_window_engine.md
BAYER_WINDOW_ENGINE -- requirements
Module: bayer_window_engine

Interface
REQ-001 Parameter PIX_W, default 8, bits per pixel.
REQ-002 Parameter DIM_W, default 13, width of dimension and coordinate fields.
REQ-003 Parameter MAX_COLS, default 4096, line-cache depth in pixels (largest legal img_width).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  level; a 0->1 edge launches one frame.
REQ-007 img_width, img_height  in  DIM_W  frame dimensions; sampled on the start edge.
REQ-008 in_valid  in  1; in_pix  in  PIX_W; in_ready  out  1: raster-order pixel stream, transfer when valid&&ready.
REQ-009 out_valid  out  1; out_ready  in  1; out_win  out  4*PIX_W: 2x2 window packed {R,G1,G2,B}, R in MSBs.
REQ-010 out_row, out_col  out  DIM_W: coordinates of the window's bottom-right pixel.
REQ-011 out_last  out  1: marks the final window of the frame.
REQ-012 busy  out  1; done  out  1 (one-cycle pulse); err_cfg  out  1 (one-cycle pulse).

Function
REQ-013 States: IDLE, FILL, RUN, FLUSH.
REQ-014 IDLE->FILL on start edge when 2<=img_width<=MAX_COLS and img_height>=2; otherwise pulse err_cfg and stay in IDLE.
REQ-015 Start edges seen outside IDLE are ignored.
REQ-016 The start edge detector register resets to 1, so a start held high through reset does not launch a frame.
REQ-017 Column counter i and row counter j clear on the start edge; i increments per accepted pixel; at i=width-1 it wraps to 0 and j increments.
REQ-018 FILL: row 0 pixels are written to the line cache at address i; no windows are produced; FILL->RUN after pixel (0,width-1).
REQ-019 RUN: per accepted pixel, cache[i] is read before being overwritten with in_pix; (cache[i], in_pix) are also held as the column-i-1 pair for the next pixel.
REQ-020 RUN: for each accepted pixel with i>=1, one window is registered: tl=cache[i-1], tr=cache[i], bl=cur[i-1], br=cur[i]; no window for i=0.
REQ-021 Window count per frame = (width-1)*(height-1).
REQ-022 Reorder on parity of the top-left pixel (row j-1, col i-1): (even,even) R=tl,G1=tr,G2=bl,B=br; (even,odd) R=tr,G1=tl,G2=br,B=bl; (odd,even) R=bl,G1=br,G2=tl,B=tr; (odd,odd) R=br,G1=bl,G2=tr,B=tl.
REQ-023 Latency: out_valid rises the cycle after the accepting in_valid&&in_ready cycle.
REQ-024 A single output register is used; in_ready = (state is FILL or RUN) && (!out_valid || out_ready).
REQ-025 While out_valid && !out_ready, all out_* signals hold stable.
REQ-026 out_valid clears on acceptance unless a new window is loaded in the same cycle.
REQ-027 After accepting pixel (height-1,width-1), go to FLUSH with in_ready=0.
REQ-028 FLUSH->IDLE when the out_last window is accepted; done pulses in that same cycle.
REQ-029 busy = 1 in FILL, RUN and FLUSH.
REQ-030 Counters are DIM_W bits and never exceed width-1 or height-1.
REQ-031 Line-cache addresses use ceil(log2(MAX_COLS)) bits.

Reset
REQ-032 rst, at any time including mid-frame, forces: state=IDLE, in_ready=0, out_valid=0, out_last=0, busy=0, done=0, err_cfg=0, out_win=0, out_row=0, out_col=0, counters=0.
REQ-033 Line-cache contents are not reset and carry no meaning after reset.
REQ-034 After reset, the next frame requires a fresh start edge.

Verification
REQ-035 4x4 frame, pixel value = 16*row+col, out_ready=1 -> 9 windows; first window {00,01,10,11} at row 1, col 1; window at row 1, col 2 is {02,01,12,11}; out_last on row 3, col 3; done pulses once.
REQ-036 Same frame with out_ready toggling 1/0 each cycle -> identical window sequence, outputs stable while stalled, no pixel lost.
REQ-037 Start edge with img_width=1 or img_width=MAX_COLS+1 -> err_cfg one-cycle pulse, busy stays 0, in_ready stays 0.
REQ-038 rst asserted after 6 pixels of a 4x4 frame -> all outputs at reset values next cycle; a new start gives a correct full frame.
REQ-039 start held high across rst release -> no frame launches; drop then raise start -> frame launches.
REQ-040 PIX_W=12, MAX_COLS=8, 8x2 frame -> 7 windows, all with (even,odd)/(even,even) ordering per column parity, out_last on col 7.
